// File: rtl/gen_layer_sequencer.sv
// Walks the generator's layer engines in order: start pulse, wait for done, guarded by a watchdog.
// Reports run completion on a valid/ready pair; abort drains the in-flight layer before going idle.
module gen_layer_sequencer #(
    parameter int NUM_LAYERS     = 4,
    parameter int IDX_W          = 2,
    parameter int TIMEOUT_CYCLES = 70000,
    parameter int CNT_W          = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    output logic                  req_ready,
    input  logic                  abort,
    input  logic                  clear_err,
    output logic [NUM_LAYERS-1:0] layer_start,
    input  logic [NUM_LAYERS-1:0] layer_done,
    output logic [IDX_W-1:0]      cur_layer,
    output logic                  busy,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CNT_W-1:0]      run_cycles,
    output logic                  error,
    output logic [IDX_W-1:0]      err_layer
);
    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD, S_ERROR, S_DRAIN} state_t;

    localparam logic [CNT_W-1:0] WD_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LAYERS - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] wdog, run_cnt;
    logic [IDX_W-1:0] cur, err_l;
    logic             cur_done, timeout;

    assign cur_done = layer_done[cur];
    // Fires on the edge where the watchdog would reach TIMEOUT_CYCLES-1, so the
    // layer gets exactly TIMEOUT_CYCLES cycles from its start pulse.
    assign timeout  = (wdog + CNT_W'(1)) == WD_LAST;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (req) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = abort ? S_DRAIN : S_WAIT;
            S_WAIT: begin
                if (abort)         state_nxt = S_DRAIN;
                else if (cur_done) state_nxt = (cur == LAST_IDX) ? S_HOLD : S_ISSUE;
                else if (timeout)  state_nxt = S_ERROR;
            end
            S_HOLD:  if (abort || out_ready) state_nxt = S_IDLE;
            S_ERROR: if (abort || clear_err) state_nxt = S_IDLE;
            S_DRAIN: if (cur_done || timeout) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog    <= '0;
            run_cnt <= '0;
            cur     <= '0;
            err_l   <= '0;
        end else begin
            case (state)
                S_IDLE: if (req) begin
                    cur     <= '0;
                    run_cnt <= '0;
                end
                S_ISSUE: begin
                    wdog <= '0;
                    if (run_cnt != '1) run_cnt <= run_cnt + CNT_W'(1);
                end
                S_WAIT: begin
                    wdog <= wdog + CNT_W'(1);
                    if (run_cnt != '1) run_cnt <= run_cnt + CNT_W'(1);
                    if (state_nxt == S_ISSUE) cur   <= cur + IDX_W'(1);
                    if (state_nxt == S_ERROR) err_l <= cur;
                end
                S_DRAIN: wdog <= wdog + CNT_W'(1);
                default: ;
            endcase
        end
    end

    always_comb begin
        layer_start = '0;
        if (state == S_ISSUE) layer_start[cur] = 1'b1;
        req_ready = (state == S_IDLE);
        busy      = (state == S_ISSUE) || (state == S_WAIT) || (state == S_DRAIN);
        out_valid = (state == S_HOLD);
        error     = (state == S_ERROR);
    end

    assign cur_layer  = cur;
    assign run_cycles = run_cnt;
    assign err_layer  = err_l;
endmodule

// File: tb/tb_gen_layer_sequencer.sv
// Bench for gen_layer_sequencer: behavioural layer engines with per-layer latency,
// a start-order scoreboard checked by a monitor, and a run-length scoreboard checked per test.
module tb_gen_layer_sequencer;
    localparam int NL = 4;
    localparam int IW = 2;
    localparam int TO = 16;
    localparam int CW = 24;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req = 1'b0, abort = 1'b0, clear_err = 1'b0, out_ready = 1'b0;
    logic [NL-1:0] model_done = '0, extra_done = '0;
    logic [NL-1:0] layer_done, layer_start;
    logic          req_ready, busy, out_valid, error;
    logic [IW-1:0] cur_layer, err_layer;
    logic [CW-1:0] run_cycles;

    int n_cmp = 0, n_bad = 0, cyc = 0;
    int lat[NL], due[NL], done_cyc[NL], start_cyc[NL];
    bit armed[NL];
    int start_q[$];
    int rc_q[$];

    assign layer_done = model_done | extra_done;

    gen_layer_sequencer #(.NUM_LAYERS(NL), .IDX_W(IW), .TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .req(req), .req_ready(req_ready), .abort(abort),
        .clear_err(clear_err), .layer_start(layer_start), .layer_done(layer_done),
        .cur_layer(cur_layer), .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
        .run_cycles(run_cycles), .error(error), .err_layer(err_layer)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Layer engines: done is high for one cycle, lat cycles after the start cycle (lat 0 = never).
    always @(negedge clk) begin
        for (int k = 0; k < NL; k++) begin
            model_done[k] = 1'b0;
            if (rst) armed[k] = 1'b0;
            else begin
                if (armed[k] && due[k] == cyc) begin
                    model_done[k] = 1'b1;
                    armed[k]      = 1'b0;
                    done_cyc[k]   = cyc;
                end
                if (layer_start[k] && lat[k] > 0) begin
                    armed[k] = 1'b1;
                    due[k]   = cyc + lat[k];
                end
            end
        end
    end

    // Start monitor: every pulse must be one-hot, in scoreboard order, and land the cycle after the prior done.
    always @(negedge clk) begin
        logic [NL-1:0] ev;
        int e;
        if (!rst && layer_start != '0) begin
            n_cmp++;
            if (start_q.size() == 0) begin
                n_bad++;
                $display("FAIL start_unexpected: got %b, wanted no start", layer_start);
            end else begin
                e = start_q.pop_front();
                ev = '0;
                ev[e] = 1'b1;
                if (layer_start !== ev) begin
                    n_bad++;
                    $display("FAIL start_order: got %b, wanted %b", layer_start, ev);
                end else begin
                    start_cyc[e] = cyc;
                    if (e > 0) begin
                        n_cmp++;
                        if (cyc != done_cyc[e-1] + 1) begin
                            n_bad++;
                            $display("FAIL start_gap layer %0d: got cycle %0d, wanted %0d", e, cyc, done_cyc[e-1] + 1);
                        end
                    end
                end
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_run(input int nstarts, input int rc);
        for (int k = 0; k < nstarts; k++) start_q.push_back(k % NL);
        if (rc >= 0) rc_q.push_back(rc);
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (out_valid) begin ok = 1'b1; break; end
            step();
        end
    endtask

    task automatic wait_start(input int k, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (layer_start[k]) begin ok = 1'b1; break; end
            step();
        end
    endtask

    task automatic set_lat(input int l0, input int l1, input int l2, input int l3);
        lat[0] = l0; lat[1] = l1; lat[2] = l2; lat[3] = l3;
    endtask

    task automatic test_reset;
        step(2);
        n_cmp++;
        if (req_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || error !== 1'b0 ||
            layer_start !== '0 || cur_layer !== '0 || run_cycles !== '0 || err_layer !== '0) begin
            n_bad++;
            $display("FAIL reset_vals: got rdy=%b busy=%b ov=%b err=%b st=%b cur=%0d rc=%0d el=%0d, wanted rdy=1 rest 0",
                     req_ready, busy, out_valid, error, layer_start, cur_layer, run_cycles, err_layer);
        end
        rst = 1'b0;
        step();
        n_cmp++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_release: got rdy=%b busy=%b, wanted 1/0", req_ready, busy);
        end
    endtask

    task automatic test_nominal;
        bit ok; int rc;
        set_lat(10, 10, 10, 10);
        req = 1'b1; push_run(4, 44); step(); req = 1'b0;
        wait_valid(ok);
        rc = rc_q.pop_front();
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL nominal_valid: got no out_valid, wanted out_valid"); end
        else if (run_cycles !== CW'(rc)) begin
            n_bad++; $display("FAIL nominal_cycles: got %0d, wanted %0d", run_cycles, rc);
        end
        out_ready = 1'b1; step(); out_ready = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_bad++; $display("FAIL nominal_ready: got ov=%b rdy=%b, wanted 0/1", out_valid, req_ready);
        end
    endtask

    task automatic test_backpressure;
        bit ok; int rc;
        req = 1'b1; push_run(4, 44); step(); req = 1'b0;
        wait_valid(ok);
        rc = rc_q.pop_front();
        for (int i = 0; i < 20; i++) begin
            n_cmp++;
            if (out_valid !== 1'b1 || run_cycles !== CW'(rc) || layer_start !== '0) begin
                n_bad++;
                $display("FAIL bp_hold cycle %0d: got ov=%b rc=%0d st=%b, wanted 1/%0d/0", i, out_valid, run_cycles, layer_start, rc);
            end
            step();
        end
        out_ready = 1'b1; step(); out_ready = 1'b0;
        n_cmp++;
        if (req_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_bad++; $display("FAIL bp_release: got rdy=%b ov=%b, wanted 1/0", req_ready, out_valid);
        end
    endtask

    task automatic test_timeout;
        bit ok; int rc;
        set_lat(10, 10, 0, 10);
        req = 1'b1; push_run(3, -1); step(); req = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (error) begin ok = 1'b1; break; end
            step();
        end
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL to_error: got error=0, wanted 1"); end
        else begin
            n_cmp++;
            if (cyc - start_cyc[2] != TO) begin
                n_bad++; $display("FAIL to_latency: got %0d cycles, wanted %0d", cyc - start_cyc[2], TO);
            end
            n_cmp++;
            if (err_layer !== IW'(2)) begin
                n_bad++; $display("FAIL to_err_layer: got %0d, wanted 2", err_layer);
            end
        end
        req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (error !== 1'b1 || busy !== 1'b0) begin
                n_bad++; $display("FAIL to_req_ignored: got err=%b busy=%b, wanted 1/0", error, busy);
            end
        end
        req = 1'b0; clear_err = 1'b1; step(); clear_err = 1'b0;
        n_cmp++;
        if (error !== 1'b0 || req_ready !== 1'b1) begin
            n_bad++; $display("FAIL to_clear: got err=%b rdy=%b, wanted 0/1", error, req_ready);
        end
        set_lat(10, 10, 10, 10);
        req = 1'b1; push_run(4, 44); step(); req = 1'b0;
        wait_valid(ok);
        rc = rc_q.pop_front();
        n_cmp++;
        if (!ok || run_cycles !== CW'(rc)) begin
            n_bad++; $display("FAIL to_rerun: got ok=%b rc=%0d, wanted 1/%0d", ok, run_cycles, rc);
        end
        out_ready = 1'b1; step(); out_ready = 1'b0;
    endtask

    task automatic test_abort;
        bit ok; int rc;
        set_lat(10, 12, 10, 10);
        req = 1'b1; push_run(2, -1); step(); req = 1'b0;
        wait_start(1, ok);
        step(7);
        abort = 1'b1; step(); abort = 1'b0;
        // Done for layer 1 lands 5 cycles after the abort cycle; drain must cover it.
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (busy !== 1'b1 || out_valid !== 1'b0) begin
                n_bad++; $display("FAIL abort_drain cycle %0d: got busy=%b ov=%b, wanted 1/0", i, busy, out_valid);
            end
            step();
        end
        n_cmp++;
        if (busy !== 1'b0 || req_ready !== 1'b1 || error !== 1'b0) begin
            n_bad++; $display("FAIL abort_idle: got busy=%b rdy=%b err=%b, wanted 0/1/0", busy, req_ready, error);
        end
        set_lat(10, 10, 10, 10);
        req = 1'b1; push_run(4, 44); step(); req = 1'b0;
        wait_valid(ok);
        rc = rc_q.pop_front();
        n_cmp++;
        if (!ok || run_cycles !== CW'(rc)) begin
            n_bad++; $display("FAIL abort_rerun: got ok=%b rc=%0d, wanted 1/%0d", ok, run_cycles, rc);
        end
        out_ready = 1'b1; step(); out_ready = 1'b0;
    endtask

    task automatic test_corners;
        bit ok; int rc;
        // Layer 0 done lands on the watchdog's final cycle: advance, no error.
        set_lat(TO - 1, 10, 10, 10);
        req = 1'b1; push_run(4, (TO - 1 + 1) + 3 * 11); step(); req = 1'b0;
        wait_valid(ok);
        rc = rc_q.pop_front();
        n_cmp++;
        if (!ok || run_cycles !== CW'(rc) || error !== 1'b0) begin
            n_bad++; $display("FAIL corner_done_vs_to: got ok=%b rc=%0d err=%b, wanted 1/%0d/0", ok, run_cycles, error, rc);
        end
        out_ready = 1'b1; step(); out_ready = 1'b0;

        set_lat(10, 10, 10, 10);
        req = 1'b1; push_run(4, 44); step(); req = 1'b0;
        wait_start(1, ok);
        step(3);
        extra_done = 4'b1001; step(); extra_done = '0;
        wait_valid(ok);
        rc = rc_q.pop_front();
        n_cmp++;
        if (!ok || run_cycles !== CW'(rc)) begin
            n_bad++; $display("FAIL corner_foreign_done: got ok=%b rc=%0d, wanted 1/%0d", ok, run_cycles, rc);
        end
        out_ready = 1'b1; step(); out_ready = 1'b0;

        req = 1'b1; push_run(4, 44); push_run(4, 44); step();
        wait_valid(ok);
        rc = rc_q.pop_front();
        n_cmp++;
        if (!ok || run_cycles !== CW'(rc)) begin
            n_bad++; $display("FAIL corner_held_req_run1: got ok=%b rc=%0d, wanted 1/%0d", ok, run_cycles, rc);
        end
        out_ready = 1'b1; step(); out_ready = 1'b0;
        n_cmp++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            n_bad++; $display("FAIL corner_held_req_idle: got rdy=%b busy=%b, wanted 1/0", req_ready, busy);
        end
        step();
        n_cmp++;
        if (req_ready !== 1'b0 || busy !== 1'b1) begin
            n_bad++; $display("FAIL corner_held_req_rerun: got rdy=%b busy=%b, wanted 0/1", req_ready, busy);
        end
        wait_valid(ok);
        rc = rc_q.pop_front();
        req = 1'b0;
        n_cmp++;
        if (!ok || run_cycles !== CW'(rc)) begin
            n_bad++; $display("FAIL corner_held_req_run2: got ok=%b rc=%0d, wanted 1/%0d", ok, run_cycles, rc);
        end
        out_ready = 1'b1; step(); out_ready = 1'b0;
        step(30);
        n_cmp++;
        if (req_ready !== 1'b1 || start_q.size() != 0) begin
            n_bad++; $display("FAIL corner_held_req_end: got rdy=%b pending=%0d, wanted 1/0", req_ready, start_q.size());
        end
    endtask

    task automatic test_async_reset;
        bit ok;
        set_lat(10, 10, 10, 10);
        req = 1'b1; push_run(4, -1); step(); req = 1'b0;
        wait_start(1, ok);
        step(3);
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (req_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || error !== 1'b0 ||
            layer_start !== '0 || cur_layer !== '0 || run_cycles !== '0) begin
            n_bad++;
            $display("FAIL async_reset: got rdy=%b busy=%b ov=%b err=%b st=%b cur=%0d rc=%0d, wanted rdy=1 rest 0",
                     req_ready, busy, out_valid, error, layer_start, cur_layer, run_cycles);
        end
        start_q.delete();
        step(2);
        rst = 1'b0;
        step(20);
        n_cmp++;
        if (req_ready !== 1'b1 || start_q.size() != 0) begin
            n_bad++; $display("FAIL async_reset_after: got rdy=%b pending=%0d, wanted 1/0", req_ready, start_q.size());
        end
    endtask

    initial begin
        for (int k = 0; k < NL; k++) begin
            lat[k] = 10; due[k] = 0; done_cyc[k] = 0; start_cyc[k] = 0; armed[k] = 1'b0;
        end
        test_reset();
        test_nominal();
        test_backpressure();
        test_timeout();
        test_abort();
        test_corners();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
